unified_mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the IF-stage fetch requester and the MEM-stage data requester.

---
 rtl/unified_mem_arbiter_pkg.sv | 19 +
 rtl/unified_mem_arbiter_if.sv | 52 +++++
 rtl/unified_mem_arbiter_arb_priority_sel.sv | 23 ++
 rtl/unified_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types and constants for the unified memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_e;

    // Value shown on if_rdata before any fetch has completed (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - requester and memory signal bundle for the unified memory arbiter
// Fetch side:  if_req, if_addr, if_kill -> arbiter; if_ready, if_rdata <- arbiter
// Data side:   d_req, d_we, d_addr, d_wdata -> arbiter; d_ready, d_rdata <- arbiter
// Memory side: mem_en, mem_we, mem_addr, mem_wdata <- arbiter; mem_rdata -> arbiter
// Status:      busy <- arbiter
// slave = arbiter view, master = pipeline/memory environment view.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_ready, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ready, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_ready, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ready, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/unified_mem_arbiter_arb_priority_sel.sv
// rtl/unified_mem_arbiter_arb_priority_sel.sv - combinational fetch/data winner select
// Ports: if_cand (fetch eligible), d_cand (data eligible), starve_hit (fetch starved to limit)
//        -> winner (OWN_NONE / OWN_IF / OWN_D)
module arb_priority_sel
    import mem_arb_pkg::*;
(
    input  logic       if_cand,
    input  logic       d_cand,
    input  logic       starve_hit,
    output arb_owner_e winner
);

    // Data normally wins; a starved fetch takes the slot instead.
    always_comb begin
        winner = OWN_NONE;
        if (d_cand && !(if_cand && starve_hit)) begin
            winner = OWN_D;
        end else if (if_cand) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port memory between fetch and data requesters
// Ports: clk; rst (asynchronous, active-high);
//        bus (unified_mem_arbiter_if.slave): fetch request/kill/ready/rdata, data request/ready/rdata,
//        memory en/we/addr/wdata/rdata, busy (arbiter not idle).
// Each access: issue (IDLE) -> MEM_LATENCY cycles in WAIT -> ready pulse in DONE -> IDLE.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    unified_mem_arbiter_if.slave bus
);

    localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int               STV_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    arb_state_e        state,      state_n;
    arb_owner_e        owner,      owner_n;
    logic [CNT_W-1:0]  cnt,        cnt_n;
    logic [STV_W-1:0]  starve,     starve_n;
    logic              own_we,     own_we_n;
    logic              kill_pend,  kill_pend_n;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_n;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_n;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              if_ready;
    logic              d_ready;

    logic              if_cand;
    logic              starve_hit;
    arb_owner_e        winner;

    // A kill in the same cycle keeps the fetch from being granted at all.
    assign if_cand    = bus.if_req && !bus.if_kill;
    assign starve_hit = (starve == STV_MAX);

    arb_priority_sel u_sel (
        .if_cand    (if_cand),
        .d_cand     (bus.d_req),
        .starve_hit (starve_hit),
        .winner     (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= OWN_NONE;
            cnt        <= '0;
            starve     <= '0;
            own_we     <= 1'b0;
            kill_pend  <= 1'b0;
            if_rdata_q <= DATA_W'(NOP_INSTR);
            d_rdata_q  <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            cnt        <= cnt_n;
            starve     <= starve_n;
            own_we     <= own_we_n;
            kill_pend  <= kill_pend_n;
            if_rdata_q <= if_rdata_n;
            d_rdata_q  <= d_rdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        cnt_n       = cnt;
        starve_n    = starve;
        own_we_n    = own_we;
        kill_pend_n = kill_pend;
        if_rdata_n  = if_rdata_q;
        d_rdata_n   = d_rdata_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if_ready    = 1'b0;
        d_ready     = 1'b0;

        // A flush of an in-flight fetch lets the memory access finish but hides its result.
        if (state != ARB_IDLE && owner == OWN_IF && bus.if_kill) begin
            kill_pend_n = 1'b1;
        end

        case (state)
            ARB_IDLE: begin
                if (winner == OWN_D) begin
                    mem_en    = 1'b1;
                    mem_we    = bus.d_we;
                    mem_addr  = bus.d_addr;
                    mem_wdata = bus.d_wdata;
                    owner_n   = OWN_D;
                    own_we_n  = bus.d_we;
                    cnt_n     = CNT_INIT;
                    state_n   = ARB_WAIT;
                    // Count data grants that overtook a waiting fetch; saturate at the limit.
                    if (bus.if_req) begin
                        if (!starve_hit) begin
                            starve_n = starve + 1'b1;
                        end
                    end else begin
                        starve_n = '0;
                    end
                end else if (winner == OWN_IF) begin
                    mem_en   = 1'b1;
                    mem_addr = bus.if_addr;
                    owner_n  = OWN_IF;
                    own_we_n = 1'b0;
                    cnt_n    = CNT_INIT;
                    starve_n = '0;
                    state_n  = ARB_WAIT;
                end
            end

            ARB_WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = ARB_DONE;
                    if (owner == OWN_D && !own_we) begin
                        d_rdata_n = bus.mem_rdata;
                    end else if (owner == OWN_IF && !kill_pend && !bus.if_kill) begin
                        if_rdata_n = bus.mem_rdata;
                    end
                end
            end

            ARB_DONE: begin
                // Bubble cycle: report completion, never issue.
                if (owner == OWN_D) begin
                    d_ready = 1'b1;
                end else if (owner == OWN_IF && !kill_pend && !bus.if_kill) begin
                    if_ready = 1'b1;
                end
                kill_pend_n = 1'b0;
                owner_n     = OWN_NONE;
                state_n     = ARB_IDLE;
            end

            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_ready  = if_ready;
    assign bus.d_ready   = d_ready;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state != ARB_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    localparam int LAT   = 1;
    localparam int SLIM  = 4;
    localparam int NRAND = 600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_load = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory environment: one-cycle registered read, write on the issue edge.
    logic [31:0] mem_model [0:63];
    logic [31:0] mem_rd_q;
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem_model[i] <= 32'h0;
            mem_model[0]  <= 32'h0050_0093;
            mem_model[16] <= 32'hDEAD_BEEF;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr[7:2]] <= bus.mem_wdata;
            else            mem_rd_q <= mem_model[bus.mem_addr[7:2]];
        end
    end
    assign bus.mem_rdata = mem_rd_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;   // returned data, or d_rdata that must survive a store
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v);
        next_cycle();
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        sample();
        chk("vec_issue", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.busy}, {1'b1, v.is_d & v.we, v.addr, 1'b0});
        if (v.is_d && v.we) chk("vec_wdata", bus.mem_wdata, v.wdata);
        next_cycle();
        sample();
        chk("vec_wait", {bus.mem_en, bus.mem_we, bus.busy, bus.if_ready, bus.d_ready}, 5'b00100);
        next_cycle();
        sample();
        chk("vec_ready", {bus.if_ready, bus.d_ready, bus.mem_en}, {~v.is_d, v.is_d, 1'b0});
        chk("vec_rdata", v.is_d ? bus.d_rdata : bus.if_rdata, v.exp);
        next_cycle();
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        sample();
        chk("vec_idle", {bus.busy, bus.mem_en, bus.if_ready, bus.d_ready}, 4'b0);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 32'h00;
            1:       return 32'h40;
            2:       return 32'h44;
            3:       return 32'h48;
            default: return 32'h4C;
        endcase
    endfunction

    // Reference model state (transaction-level: slot timing by arithmetic on cycle numbers).
    logic [31:0] ref_mem [0:63];
    int          free_at, ready_at, grant_c, owner_m, starve_m;
    logic        killed, ld_m, exp_en, exp_we, exp_ir, exp_dr, exp_busy, seen_if, seen_d;
    logic [31:0] res_m, exp_addr, exp_wdata, exp_if, exp_d;

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.if_kill = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;

        vecs[0] = '{1'b0, 1'b0, 32'h00, 32'h0,         32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h44, 32'h1234_5678, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h44, 32'h0,         32'h1234_5678};
        vecs[4] = '{1'b0, 1'b0, 32'h44, 32'h0,         32'h1234_5678};
        vecs[5] = '{1'b1, 1'b1, 32'h48, 32'hCAFE_F00D, 32'h1234_5678};
        vecs[6] = '{1'b0, 1'b0, 32'h48, 32'h0,         32'hCAFE_F00D};
        vecs[7] = '{1'b0, 1'b0, 32'h40, 32'h0,         32'hDEAD_BEEF};

        // Reset values
        next_cycle();
        next_cycle();
        mem_load = 1'b0;
        sample();
        chk("rst_ctrl", {bus.busy, bus.if_ready, bus.d_ready, bus.mem_en, bus.mem_we}, 5'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0000_0013);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_mem_bus", {bus.mem_addr, bus.mem_wdata}, 64'h0);
        next_cycle();
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during WAIT drops the fetch
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        sample();
        chk("rstw_issue", bus.mem_en, 1'b1);
        next_cycle();
        bus.if_req = 1'b0; rst = 1'b1;
        #1;
        chk("rstw_state", {bus.busy, bus.if_ready}, 2'b00);
        chk("rstw_if_rdata", bus.if_rdata, 32'h0000_0013);
        next_cycle();
        rst = 1'b0;
        sample();
        chk("rstw_no_ready", {bus.busy, bus.if_ready, bus.d_ready}, 3'b000);

        // Conflict: data first, fetch right after the bubble
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        sample();
        chk("conf_issue_d", {bus.mem_en, bus.mem_addr}, {1'b1, 32'h40});
        next_cycle();
        next_cycle();
        sample();
        chk("conf_d_ready", {bus.d_ready, bus.if_ready, bus.d_rdata}, {2'b10, 32'hDEAD_BEEF});
        next_cycle();
        bus.d_req = 1'b0;
        sample();
        chk("conf_issue_if", {bus.mem_en, bus.mem_addr}, {1'b1, 32'h0});
        next_cycle();
        next_cycle();
        sample();
        chk("conf_if_ready", {bus.if_ready, bus.d_ready, bus.if_rdata}, {2'b10, 32'h0050_0093});
        next_cycle();
        bus.if_req = 1'b0;

        // Starvation: four data grants, then fetch, then data again (counter cleared)
        for (int k = 0; k < 18; k++) begin
            if (k == 0) begin
                bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
                bus.if_req = 1'b1; bus.if_addr = 32'h0;
            end
            if (k == 16) begin
                bus.d_req = 1'b0; bus.if_req = 1'b0;
            end
            sample();
            if (k % 3 == 0 && k <= 15)
                chk("starve_grant", {bus.mem_en, bus.mem_addr}, {1'b1, (k == 12) ? 32'h0 : 32'h40});
            if (k == 14) chk("starve_if_ready", {bus.if_ready, bus.if_rdata}, {1'b1, 32'h0050_0093});
            if (k == 17) chk("drop_req_ready", {bus.d_ready, bus.d_rdata}, {1'b1, 32'hDEAD_BEEF});
            next_cycle();
        end

        // Kill an in-flight fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        sample();
        chk("kill_issue", {bus.mem_en, bus.mem_addr}, {1'b1, 32'h40});
        next_cycle();
        bus.if_kill = 1'b1; bus.if_req = 1'b0;
        next_cycle();
        bus.if_kill = 1'b0;
        sample();
        chk("kill_no_ready", {bus.if_ready, bus.if_rdata}, {1'b0, 32'h0050_0093});
        next_cycle();
        sample();
        chk("kill_idle", {bus.busy, bus.mem_en}, 2'b00);

        // Kill in IDLE blocks only the fetch
        next_cycle();
        bus.if_req = 1'b1; bus.if_kill = 1'b1; bus.if_addr = 32'h0;
        sample();
        chk("kill_idle_block", bus.mem_en, 1'b0);
        next_cycle();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
        sample();
        chk("kill_idle_data", {bus.mem_en, bus.mem_addr}, {1'b1, 32'h44});
        next_cycle();
        bus.if_req = 1'b0; bus.if_kill = 1'b0;
        next_cycle();
        sample();
        chk("kill_idle_dready", {bus.d_ready, bus.if_ready, bus.d_rdata}, {2'b10, 32'h1234_5678});
        next_cycle();
        bus.d_req = 1'b0;

        // Randomized traffic against the reference model
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        ref_mem[0] = 32'h0050_0093; ref_mem[16] = 32'hDEAD_BEEF;
        ref_mem[17] = 32'h1234_5678; ref_mem[18] = 32'hCAFE_F00D;
        free_at = 0; ready_at = -10; grant_c = -10; owner_m = 0; starve_m = 0;
        killed = 0; ld_m = 0; res_m = 0; seen_if = 0; seen_d = 0;
        exp_if = 32'h0000_0013; exp_d = 32'h0;

        for (int c = 0; c < NRAND; c++) begin
            next_cycle();
            if (bus.d_req && seen_d) bus.d_req = 1'b0;
            else if (!bus.d_req && $urandom_range(0, 1) == 1) begin
                bus.d_req = 1'b1; bus.d_we = ($urandom_range(0, 2) == 0);
                bus.d_addr = pick_addr(); bus.d_wdata = $urandom();
            end
            if (bus.if_kill) begin
                bus.if_kill = 1'b0; bus.if_req = 1'b0;
            end else if (bus.if_req && seen_if) bus.if_req = 1'b0;
            else if (!bus.if_req && $urandom_range(0, 1) == 1) begin
                bus.if_req = 1'b1; bus.if_addr = pick_addr();
            end else if (bus.if_req && !(owner_m == 1 && c <= ready_at) && $urandom_range(0, 3) == 0)
                bus.if_addr = pick_addr();
            if ($urandom_range(0, 9) == 0 && !(owner_m == 1 && c == ready_at)) bus.if_kill = 1'b1;

            sample();
            exp_en = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;
            if (owner_m == 1 && c > grant_c && c <= ready_at && bus.if_kill) killed = 1;
            if (c >= free_at) begin
                if (bus.d_req && !(bus.if_req && !bus.if_kill && starve_m >= SLIM)) begin
                    exp_en = 1; exp_we = bus.d_we; exp_addr = bus.d_addr; exp_wdata = bus.d_wdata;
                    owner_m = 2; ld_m = !bus.d_we;
                    if (bus.d_we) ref_mem[bus.d_addr[7:2]] = bus.d_wdata;
                    else res_m = ref_mem[bus.d_addr[7:2]];
                    starve_m = bus.if_req ? ((starve_m < SLIM) ? starve_m + 1 : SLIM) : 0;
                end else if (bus.if_req && !bus.if_kill) begin
                    exp_en = 1; exp_addr = bus.if_addr; owner_m = 1;
                    res_m = ref_mem[bus.if_addr[7:2]]; starve_m = 0;
                end
                if (exp_en) begin
                    grant_c = c; ready_at = c + LAT + 1; free_at = c + LAT + 2; killed = 0;
                end
            end
            exp_ir = 0; exp_dr = 0;
            if (c == ready_at) begin
                if (owner_m == 2) begin
                    exp_dr = 1;
                    if (ld_m) exp_d = res_m;
                end else if (owner_m == 1 && !killed) begin
                    exp_ir = 1; exp_if = res_m;
                end
            end
            exp_busy = (c > grant_c && c < free_at);

            chk("rand_mem", {bus.mem_en, bus.mem_en & bus.mem_we, bus.mem_en ? bus.mem_addr : 32'h0},
                {exp_en, exp_we, exp_addr});
            if (exp_en && exp_we) chk("rand_wdata", bus.mem_wdata, exp_wdata);
            chk("rand_ready", {bus.if_ready, bus.d_ready, bus.busy}, {exp_ir, exp_dr, exp_busy});
            chk("rand_rdata", {bus.if_rdata, bus.d_rdata}, {exp_if, exp_d});
            seen_if = exp_ir; seen_d = exp_dr;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
